// File: rtl/bg_pixel_packer.sv
// Packs 8-bit background pixels into little-endian 32-bit words through a 2-entry output FIFO.
// Optional macro BG_PACKER_LINE_MARKERS_EN adds a per-word end-of-line flag (word_eol).
`timescale 1ns/1ps
module bg_pixel_packer #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        word_valid,
  output logic [31:0] word_data,
  input  logic        word_ready,
  output logic        word_last,
`ifdef BG_PACKER_LINE_MARKERS_EN
  output logic        word_eol,
`endif
  output logic        frame_done
);

  localparam int COLS  = IMG_WIDTH / 4;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

  logic [1:0]       lane_q, lane_d;
  logic [23:0]      pack_q, pack_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [31:0]      mem_data_q [2];
  logic [31:0]      mem_data_d [2];
  logic [1:0]       mem_last_q, mem_last_d;
  logic             frame_done_q, frame_done_d;
`ifdef BG_PACKER_LINE_MARKERS_EN
  logic [1:0]       mem_eol_q, mem_eol_d;
`endif

  logic pix_fire;
  logic push;
  logic pop;
  logic at_eol;

  // Ready depends only on registered state, so word_ready never reaches pix_ready.
  assign pix_ready  = !(lane_q == 2'd3 && cnt_q == 2'd2);
  assign word_valid = (cnt_q != 2'd0);
  assign word_data  = word_valid ? mem_data_q[rd_ptr_q] : 32'h0;
  assign word_last  = word_valid ? mem_last_q[rd_ptr_q] : 1'b0;
`ifdef BG_PACKER_LINE_MARKERS_EN
  assign word_eol   = word_valid ? mem_eol_q[rd_ptr_q] : 1'b0;
`endif
  assign frame_done = frame_done_q;

  assign pix_fire = pix_valid && pix_ready;
  assign push     = pix_fire && (lane_q == 2'd3);
  assign pop      = word_valid && word_ready;
  assign at_eol   = (col_q == COL_MAX);

  always_comb begin
    lane_d       = lane_q;
    pack_d       = pack_q;
    col_d        = col_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_data_d   = mem_data_q;
    mem_last_d   = mem_last_q;
`ifdef BG_PACKER_LINE_MARKERS_EN
    mem_eol_d    = mem_eol_q;
`endif
    frame_done_d = pop && mem_last_q[rd_ptr_q];

    if (pix_fire) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    pack_d[7:0]   = pix_data;
        2'd1:    pack_d[15:8]  = pix_data;
        2'd2:    pack_d[23:16] = pix_data;
        default: pack_d        = pack_q;
      endcase
    end

    // The fourth pixel goes straight into the FIFO entry alongside the three held lanes.
    if (push) begin
      mem_data_d[wr_ptr_q] = {pix_data, pack_q};
      mem_last_d[wr_ptr_q] = at_eol && (row_q == ROW_MAX);
`ifdef BG_PACKER_LINE_MARKERS_EN
      mem_eol_d[wr_ptr_q]  = at_eol;
`endif
      wr_ptr_d = !wr_ptr_q;
      if (at_eol) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (pop) rd_ptr_d = !rd_ptr_q;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q       <= '0;
      pack_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      mem_data_q   <= '{default: 32'h0};
      mem_last_q   <= '0;
`ifdef BG_PACKER_LINE_MARKERS_EN
      mem_eol_q    <= '0;
`endif
      frame_done_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      col_q        <= col_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_data_q   <= mem_data_d;
      mem_last_q   <= mem_last_d;
`ifdef BG_PACKER_LINE_MARKERS_EN
      mem_eol_q    <= mem_eol_d;
`endif
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: doc/bg_pixel_packer.md
BG_PIXEL_PACKER -- requirements
Module: bg_pixel_packer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 320, meaning pixels per line; a multiple of 4, minimum 4.
REQ-002 SHALL have parameter IMG_HEIGHT, default 240, meaning lines per frame; minimum 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port pix_valid, input, 1 bit: the upstream 8-bit background pixel is valid.
REQ-006 SHALL have port pix_data, input, 8 bits: the saturated integer background pixel from the float-to-integer stage.
REQ-007 SHALL have port pix_ready, output, 1 bit: the block accepts a pixel this cycle.
REQ-008 SHALL have port word_valid, output, 1 bit: word_data is valid.
REQ-009 SHALL have port word_data, output, 32 bits: four packed pixels.
REQ-010 SHALL have port word_ready, input, 1 bit: downstream accepts the word.
REQ-011 SHALL have port word_last, output, 1 bit: the current word is the last word of the frame.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the frame's last word transfers.

Function
REQ-013 SHALL transfer a pixel on a clock edge where pix_valid=1 and pix_ready=1; a transfer on the other interface occurs where word_valid=1 and word_ready=1.
REQ-014 SHALL pack pixels little-endian: 1st pixel to [7:0], 2nd to [15:8], 3rd to [23:16], 4th to [31:24].
REQ-015 SHALL use a 2-bit lane counter (0..3) that increments on each pixel transfer and wraps 3->0.
REQ-016 SHALL push the completed word into a 2-entry output FIFO on the 4th pixel transfer (lane=3).
REQ-017 SHALL make that word visible on word_valid/word_data the next cycle, provided the FIFO was empty; latency is 1 cycle.
REQ-018 SHALL drive pix_ready = NOT(lane=3 AND fifo_count=2), derived only from registered state, with no combinational path from word_ready.
REQ-019 SHALL, on a simultaneous push and pop, leave fifo_count unchanged and preserve word order.
REQ-020 SHALL keep word_data and word_last stable while word_valid=1 and word_ready=0.
REQ-021 SHALL track a word column counter (0..IMG_WIDTH/4-1) and a row counter (0..IMG_HEIGHT-1), both advanced at push time.
REQ-022 SHALL wrap the column counter to 0 at the end of a line and increment the row counter; the row counter wraps to 0 at the end of a frame.
REQ-023 SHALL store word_last with each FIFO entry, set for the word at column IMG_WIDTH/4-1 and row IMG_HEIGHT-1.
REQ-024 SHALL pulse frame_done for exactly one cycle, the cycle after a word with word_last=1 is popped.
REQ-025 SHALL hold all state when pix_valid=0 and no pop occurs; pixel gaps do not corrupt packing.

Reset
REQ-026 SHALL, while rst_n=0 (immediately, without waiting for clk), clear the lane, column, row and fifo_count state.
REQ-027 SHALL hold word_valid=0, word_data=0, word_last=0, frame_done=0 and pix_ready=1 during reset.
REQ-028 SHALL discard a partially packed word or any FIFO contents when reset asserts mid-frame; the next pixel after release is pixel 0 of a new frame.

Configuration
REQ-029 SHALL, when macro BG_PACKER_LINE_MARKERS_EN is defined, add output port word_eol (1 bit), stored per FIFO entry and set for the word at column IMG_WIDTH/4-1 of every row.
REQ-030 SHALL, without BG_PACKER_LINE_MARKERS_EN, omit port word_eol and its storage; all other behaviour is identical.

Verification
REQ-031 SHALL cover: reset, then pixels 0x11,0x22,0x33,0x44 on consecutive cycles with word_ready=1 -> word_data=0x44332211 with word_valid=1 one cycle after 0x44 is accepted.
REQ-032 SHALL cover: word_ready=0, then 12 pixels streamed -> two words held in the FIFO, pix_ready=0 while lane=3; after word_ready=1, words emerge in order and no pixel is lost.
REQ-033 SHALL cover: IMG_WIDTH=8, IMG_HEIGHT=2, 16 pixels sent -> word_last=1 on word 4 only, and a single frame_done pulse the cycle after its transfer.
REQ-034 SHALL cover: rst_n=0 asserted after 2 pixels, then pixels 0xA0..0xA3 -> first word_data=0xA3A2A1A0 with word_last=0.
REQ-035 SHALL cover: random pix_valid/word_ready gaps over 3 frames -> output matches the reference packing model and frame_done fires 3 times.
REQ-036 SHALL cover, with BG_PACKER_LINE_MARKERS_EN defined, IMG_WIDTH=8 -> word_eol=1 on every 2nd word.
